data_mem_ctrl: RTL

Responder for the processor's data-memory port: receives address, write enable and write data from the core and returns read data. Combines a single-port data RAM with a small memory-mapped peripheral window: GPIO output and input registers, plus a prescaled 8-bit timer with a compare-match interrupt. It sits beside the processor top and connects directly to its data-RAM address, write-enable, write-data and read-data signals.

---
 rtl/data_mem_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: single-port read-first RAM plus IO window (GPIO, prescaled timer, IRQ).
// Read data is registered (1-cycle latency); never stalls, one access accepted every cycle.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic                  tmr_irq
);

  localparam int RAM_DEPTH = (1 << ADDR_WIDTH) - 16;
  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
  localparam logic [3:0] OFF_TMR_CNT  = 4'd2;
  localparam logic [3:0] OFF_TMR_CMP  = 4'd3;
  localparam logic [3:0] OFF_TMR_CTRL = 4'd4;
  localparam logic [3:0] OFF_TMR_STAT = 4'd5;
  localparam logic [3:0] OFF_PRESCALE = 4'd6;

  logic [DATA_WIDTH-1:0] r_ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_gpio_out;
  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic [2:0]            r_ctrl;
  logic                  r_match;
  logic [DATA_WIDTH-1:0] r_prescale;
  logic [DATA_WIDTH-1:0] r_ps;
  logic                  r_irq;

  logic                  w_io_sel;
  logic [3:0]            w_off;
  logic                  w_io_we;
  logic [DATA_WIDTH-1:0] w_ram_rd;
  logic [DATA_WIDTH-1:0] w_io_rd;
  logic                  w_en;
  logic                  w_tick;
  logic                  w_match_hit;
  logic [2:0]            w_ctrl_nxt;
  logic                  w_match_nxt;

  assign w_io_sel = &mem_addr[ADDR_WIDTH-1:4];
  assign w_off    = mem_addr[3:0];
  assign w_io_we  = mem_we & w_io_sel;

  // RAM has no reset; the read below sees pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (mem_we && !w_io_sel && !rst) begin
      r_ram[mem_addr] <= mem_data_i;
    end
  end

  assign w_ram_rd = r_ram[mem_addr];

  always_comb begin
    w_io_rd = '0;
    case (w_off)
      OFF_GPIO_OUT: w_io_rd = r_gpio_out;
      OFF_GPIO_IN:  w_io_rd = r_sync2;
      OFF_TMR_CNT:  w_io_rd = r_cnt;
      OFF_TMR_CMP:  w_io_rd = r_cmp;
      OFF_TMR_CTRL: w_io_rd = {{(DATA_WIDTH-3){1'b0}}, r_ctrl};
      OFF_TMR_STAT: w_io_rd = {{(DATA_WIDTH-1){1'b0}}, r_match};
      OFF_PRESCALE: w_io_rd = r_prescale;
      default:      w_io_rd = '0;
    endcase
  end

  assign w_en        = r_ctrl[0];
  assign w_tick      = w_en && (r_ps == r_prescale);
  assign w_match_hit = w_tick && (r_cnt == r_cmp);

  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_match_nxt = r_match;
    if (w_io_we && (w_off == OFF_TMR_CTRL)) begin
      w_ctrl_nxt = mem_data_i[2:0];
    end
    // A match in the same cycle as a clear keeps the flag set.
    if (w_match_hit) begin
      w_match_nxt = 1'b1;
    end else if (w_io_we && (w_off == OFF_TMR_STAT) && mem_data_i[0]) begin
      w_match_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cnt      <= '0;
      r_cmp      <= '0;
      r_ctrl     <= '0;
      r_match    <= 1'b0;
      r_prescale <= '0;
      r_ps       <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_rdata <= w_io_sel ? w_io_rd : w_ram_rd;
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_io_we && (w_off == OFF_GPIO_OUT)) r_gpio_out <= mem_data_i;
      if (w_io_we && (w_off == OFF_TMR_CMP))  r_cmp      <= mem_data_i;
      if (w_io_we && (w_off == OFF_PRESCALE)) r_prescale <= mem_data_i;
      r_ctrl  <= w_ctrl_nxt;
      r_match <= w_match_nxt;
      // Registered from next-state values so the IRQ rises together with MATCH.
      r_irq   <= w_match_nxt & w_ctrl_nxt[2];

      if ((w_io_we && (w_off == OFF_PRESCALE)) || !w_en || w_tick) begin
        r_ps <= '0;
      end else begin
        r_ps <= r_ps + ONE;
      end

      if (w_tick) begin
        if (w_match_hit && r_ctrl[1]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end

  assign mem_data_o = r_rdata;
  assign gpio_out   = r_gpio_out;
  assign tmr_irq    = r_irq;

endmodule
